// File: rtl/mouse_cursor_tracker.sv
// Absolute, clamped screen cursor built from PS/2 mouse packets, with per-button
// press/release pulses and a left-button double-click detector.
module mouse_cursor_tracker #(
  parameter int H_PIX     = 640,
  parameter int V_PIX     = 480,
  parameter int SPEED_SHL = 0,
  parameter int DBL_CYC   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] xm,
  input  logic [8:0] ym,
  input  logic [2:0] btnm,
  input  logic       m_done_tick,
  input  logic       recenter,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic [2:0] btn,
  output logic [2:0] btn_press,
  output logic [2:0] btn_rel,
  output logic       dbl_click,
  output logic       upd_tick
);

  localparam int                CW       = $clog2(DBL_CYC + 1);
  localparam logic [9:0]        PX_C     = 10'(H_PIX / 2);
  localparam logic [9:0]        PY_C     = 10'(V_PIX / 2);
  localparam logic signed [12:0] X_MAX   = 13'(H_PIX - 1);
  localparam logic signed [12:0] Y_MAX   = 13'(V_PIX - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DBL_CYC - 1);

  typedef enum logic {IDLE, WAIT} dc_state_t;

  dc_state_t         state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              dbl_next;

  logic signed [12:0] xs, ys, dx, dy, nx, ny;
  logic [2:0]         press_now, rel_now;
  logic               left_press;

  function automatic logic [9:0] clamp(input logic signed [12:0] v,
                                       input logic signed [12:0] lim);
    if (v < 13'sd0)
      return 10'd0;
    else if (v > lim)
      return lim[9:0];
    else
      return v[9:0];
  endfunction

  assign xs = {{4{xm[8]}}, xm};
  assign ys = {{4{ym[8]}}, ym};
  assign dx = xs <<< SPEED_SHL;
  assign dy = ys <<< SPEED_SHL;
  // PS/2 +y points up while screen rows count downward
  assign nx = $signed({3'b000, px}) + dx;
  assign ny = $signed({3'b000, py}) - dy;

  assign press_now  = btnm & ~btn;
  assign rel_now    = ~btnm & btn;
  assign left_press = m_done_tick & press_now[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px        <= PX_C;
      py        <= PY_C;
      btn       <= 3'b000;
      btn_press <= 3'b000;
      btn_rel   <= 3'b000;
      upd_tick  <= 1'b0;
    end else begin
      btn_press <= 3'b000;
      btn_rel   <= 3'b000;
      upd_tick  <= 1'b0;
      if (m_done_tick) begin
        btn       <= btnm;
        btn_press <= press_now;
        btn_rel   <= rel_now;
        upd_tick  <= 1'b1;
        px        <= clamp(nx, X_MAX);
        py        <= clamp(ny, Y_MAX);
      end
      // Recentre overrides any packet motion on the same cycle
      if (recenter) begin
        px       <= PX_C;
        py       <= PY_C;
        upd_tick <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dbl_click <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dbl_click <= dbl_next;
    end
  end

  // The window counter never passes DBL_CYC-1 while waiting, so any press in WAIT qualifies
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dbl_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (left_press) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (left_press) begin
          dbl_next   = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
